// File: rtl/seq_rep_add_mult.sv
// seq_rep_add_mult: unsigned multiplier built from repeated addition.
// A request in IDLE latches the operands. RUN then adds the addend to the accumulator
// once per cycle while the count register is non-zero. DONE pulses for one cycle with
// the product.
// Optional build macro REP_ADD_SWAP_EN: iterate over the smaller operand to shorten
// latency. The product value is the same with or without it.
module seq_rep_add_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [WIDTH-1:0]   add_r;
    logic [WIDTH-1:0]   cnt_r;
    logic [2*WIDTH-1:0] acc;

    logic [WIDTH-1:0]   ld_add;
    logic [WIDTH-1:0]   ld_cnt;
    logic               cnt_zero;

    assign cnt_zero = (cnt_r == '0);

    // Operand routing on the accepting edge: which value is added, which one counts
`ifdef REP_ADD_SWAP_EN
    always_comb begin
        ld_add = a;
        ld_cnt = b;
        if (b > a) begin
            ld_add = b;
            ld_cnt = a;
        end
    end
`else
    always_comb begin
        ld_add = a;
        ld_cnt = b;
    end
`endif

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt_zero) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; busy/done are registered decodes of the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
        end
    end

    // Datapath: latch operands, accumulate, publish the product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_r   <= '0;
            cnt_r   <= '0;
            acc     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        add_r <= ld_add;
                        cnt_r <= ld_cnt;
                        acc   <= '0;
                    end
                end
                RUN: begin
                    if (cnt_zero) begin
                        product <= acc;
                    end else begin
                        // Full 2*WIDTH-bit add; (2^WIDTH-1)^2 still fits, so no wrap
                        acc   <= acc + {{WIDTH{1'b0}}, add_r};
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_rep_add_mult.sv
// Directed bench for seq_rep_add_mult (WIDTH=8) with a product/latency scoreboard.
module tb_seq_rep_add_mult;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    int          lat_q[$];

    seq_rep_add_mult #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected cycle of the done pulse, counted from the accepting edge
    function automatic int model_lat(input logic [W-1:0] ia, input logic [W-1:0] ib);
        int n;
`ifdef REP_ADD_SWAP_EN
        n = (ia < ib) ? int'(ia) : int'(ib);
`else
        n = int'(ib);
`endif
        return n + 2;
    endfunction

    function automatic logic [31:0] model_prod(input logic [W-1:0] ia, input logic [W-1:0] ib);
        return 32'(int'(ia) * int'(ib));
    endfunction

    // Present a request for one edge, then scramble the operands during RUN.
    // Returns at the falling edge of cycle 1.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib);
        @(negedge clk);
        a = ia;
        b = ib;
        start = 1'b1;
        exp_q.push_back(model_prod(ia, ib));
        lat_q.push_back(model_lat(ia, ib));
        @(negedge clk);
        start = 1'b0;
        a = ~ia;
        b = ~ib;
    endtask

    // Wait for done, starting at the falling edge of cycle 'cyc0'. Compare against
    // the scoreboard, then check that the pulse is single and the product holds.
    task automatic wait_done(input int cyc0);
        int          cyc;
        logic [31:0] ep;
        int          el;
        cyc = cyc0;
        while (done !== 1'b1 && cyc < cyc0 + 600) begin
            @(negedge clk);
            cyc++;
        end
        ep = exp_q.pop_front();
        el = lat_q.pop_front();
        check("done_seen", {31'd0, done}, 32'd1);
        if (done !== 1'b1) return;
        check("latency", cyc, el);
        check("product", {16'd0, product}, ep);
        check("busy_in_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("done_single", {31'd0, done}, 32'd0);
        check("product_hold", {16'd0, product}, ep);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        check("rst_product", {16'd0, product}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Basic and boundary operands
        issue(8'd7, 8'd5);
        check("run_busy", {31'd0, busy}, 32'd1);
        wait_done(1);
        issue(8'd3, 8'd200);
        wait_done(1);
        issue(8'd0, 8'd9);
        wait_done(1);
        issue(8'd255, 8'd0);
        wait_done(1);
        issue(8'd255, 8'd255);
        wait_done(1);
        issue(8'd13, 8'd11);
        wait_done(1);

        // A request during RUN is ignored
        issue(8'd10, 8'd10);
        start = 1'b1;
        a = 8'd1;
        b = 8'd1;
        @(negedge clk);
        start = 1'b0;
        check("midrun_busy", {31'd0, busy}, 32'd1);
        wait_done(2);

        // start held high: the next request is taken on the first IDLE edge
        @(negedge clk);
        a = 8'd2;
        b = 8'd3;
        start = 1'b1;
        exp_q.push_back(model_prod(8'd2, 8'd3));
        lat_q.push_back(model_lat(8'd2, 8'd3));
        @(negedge clk);
        wait_done(1);
        a = 8'd4;
        b = 8'd5;
        exp_q.push_back(model_prod(8'd4, 8'd5));
        lat_q.push_back(model_lat(8'd4, 8'd5));
        check("held_idle_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("held_run_busy", {31'd0, busy}, 32'd1);
        wait_done(1);

        // Reset in the middle of RUN aborts the operation
        issue(8'd50, 8'd50);
        repeat (19) @(negedge clk);
        check("pre_abort_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_product", {16'd0, product}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        exp_q.delete();
        lat_q.delete();
        repeat (3) @(negedge clk);
        check("abort_no_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        issue(8'd2, 8'd3);
        wait_done(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_rep_add_mult.md
SEQ_REP_ADD_MULT -- requirements
Module: seq_rep_add_mult

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  WIDTH  multiplicand, unsigned; sampled on the accepting edge.
REQ-006 b  input  WIDTH  multiplier, unsigned; sampled on the accepting edge.
REQ-007 busy  output  1  high while in RUN state.
REQ-008 done  output  1  single-cycle pulse; product valid.
REQ-009 product  output  2*WIDTH  result; holds last result until the next accepted start.

Function
REQ-010 FSM states IDLE, RUN, DONE; one-hot or binary encoding, implementer's choice.
REQ-011 IDLE with start=1 at a rising edge: latch addend register ADD_R and count register CNT_R from a/b, clear accumulator ACC to 0, go to RUN.
REQ-012 IDLE with start=0: remain in IDLE, all registers hold.
REQ-013 RUN with CNT_R != 0: ACC <= ACC + ADD_R (2*WIDTH-bit add, no truncation), CNT_R <= CNT_R - 1, remain in RUN.
REQ-014 RUN with CNT_R == 0: product <= ACC, go to DONE.
REQ-015 DONE: done=1 for exactly this one cycle, then unconditionally go to IDLE.
REQ-016 Latency: with N = final CNT_R load value, done is high during cycle N+2 after the accepting edge (counting that edge's following cycle as 1).
REQ-017 start asserted in RUN or DONE is ignored; no queuing; a/b changes during RUN do not affect the result.
REQ-018 start held high continuously: a new operation is accepted on the first IDLE edge after DONE.
REQ-019 Zero operand: CNT_R == 0 at RUN entry gives product 0 and done in cycle 2; no add is performed.
REQ-020 Maximum operands (2^WIDTH-1 each): product = (2^WIDTH-1)^2, exact, no wrap.
REQ-021 busy is a registered decode of the RUN state; busy and done are never high simultaneously.

Reset
REQ-022 rst_n low asynchronously forces IDLE, ACC=0, ADD_R=0, CNT_R=0, product=0, busy=0, done=0.
REQ-023 Reset asserted mid-RUN aborts the operation; no done pulse is generated and product reads 0.
REQ-024 After rst_n deasserts, the first start is accepted on the first rising edge at which it is sampled high.

Configuration
REQ-025 Macro REP_ADD_SWAP_EN selects operand-swap optimisation.
REQ-026 With REP_ADD_SWAP_EN defined: on the accepting edge, CNT_R loads min(a,b) and ADD_R loads max(a,b) (a when equal); iterations = min(a,b).
REQ-027 Without REP_ADD_SWAP_EN: CNT_R loads b, ADD_R loads a unconditionally; iterations = b.
REQ-028 Product value is identical in both builds; only latency differs.

Verification (WIDTH=8)
REQ-029 Reset, start with a=7 b=5 -> product=35, done one cycle; latency 7 cycles (no swap) / 7 (swap).
REQ-030 a=3 b=200 -> product=600; done at cycle 202 without REP_ADD_SWAP_EN, cycle 5 with it.
REQ-031 a=0 b=9 -> product=0; no-swap: 11 cycles, swap: 2 cycles; b=0 a=255 -> product=0, 2 cycles both builds.
REQ-032 a=255 b=255 -> product=65025 (0xFE01), no overflow or truncation.
REQ-033 Start a=10 b=10, pulse start again with a=1 b=1 mid-RUN -> product=100, second request ignored, busy stays high until DONE.
REQ-034 Start a=50 b=50, drop rst_n at cycle 20 -> immediate IDLE, product=0, busy=0, no done; next start a=2 b=3 -> product=6.
